// File: rtl/lector_mascara.sv
// Mask coefficient reader: on a start pulse it fetches the N*N coefficients from
// memory and streams them row-major, tagged with (fila, columna), over valid/ready.
module lector_mascara #(
  parameter int BITS_DIRECCION_MEM = 10,
  parameter int BITS_MASCARA       = 3,
  parameter int BITS_DATOS_MEM     = 21
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          iniciar,
  input  logic [BITS_DIRECCION_MEM-1:0] direccion_inicio,
  input  logic [BITS_MASCARA-1:0]       tamano,
  output logic                          mem_lectura,
  output logic [BITS_DIRECCION_MEM-1:0] mem_direccion,
  input  logic [BITS_DATOS_MEM-1:0]     mem_datos,
  output logic [BITS_DATOS_MEM-1:0]     coeficiente,
  output logic [BITS_MASCARA-1:0]       coeficiente_fila,
  output logic [BITS_MASCARA-1:0]       coeficiente_columna,
  output logic                          coeficiente_valido,
  input  logic                          coeficiente_listo,
  output logic                          ocupado,
  output logic                          fin
);
  localparam int TW = 2 * BITS_MASCARA;

  typedef enum logic [1:0] {REPOSO, LEYENDO, FIN} estado_t;

  typedef struct packed {
    logic [BITS_DATOS_MEM-1:0] dato;
    logic [BITS_MASCARA-1:0]   fila;
    logic [BITS_MASCARA-1:0]   col;
  } entrada_t;

  estado_t                         r_estado;
  logic [BITS_DIRECCION_MEM-1:0]   r_base, r_dir;
  logic [BITS_MASCARA-1:0]         r_n, r_fila, r_col, r_pfila, r_pcol;
  logic [TW-1:0]                   r_total, r_k, r_emit;
  logic                            r_pend;
  logic [1:0]                      r_cnt;
  entrada_t                        r_fifo [0:1];

  logic                            w_pop, w_issue;
  logic [2:0]                      w_ocup;
  logic [BITS_DIRECCION_MEM-1:0]   w_dir;
  entrada_t                        w_new;

  // Occupancy counts the read in flight so the FIFO can never overflow.
  assign w_pop   = (r_cnt != 2'd0) && coeficiente_listo;
  assign w_ocup  = 3'(r_cnt) + 3'(r_pend) - 3'(w_pop);
  assign w_issue = (r_estado == LEYENDO) && (r_k < r_total) && (w_ocup < 3'd2);
  assign w_dir   = r_base + BITS_DIRECCION_MEM'(r_k);
  assign w_new   = '{dato: mem_datos, fila: r_pfila, col: r_pcol};

  assign mem_lectura         = w_issue;
  assign mem_direccion       = w_issue ? w_dir : r_dir;
  assign coeficiente         = r_fifo[0].dato;
  assign coeficiente_fila    = r_fifo[0].fila;
  assign coeficiente_columna = r_fifo[0].col;
  assign coeficiente_valido  = (r_cnt != 2'd0);
  assign ocupado             = (r_estado != REPOSO);
  assign fin                 = (r_estado == FIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado  <= REPOSO;
      r_base    <= '0;
      r_dir     <= '0;
      r_n       <= '0;
      r_fila    <= '0;
      r_col     <= '0;
      r_pfila   <= '0;
      r_pcol    <= '0;
      r_total   <= '0;
      r_k       <= '0;
      r_emit    <= '0;
      r_pend    <= 1'b0;
      r_cnt     <= '0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      case (r_estado)
        REPOSO: if (iniciar) begin
          r_base   <= direccion_inicio;
          r_n      <= tamano;
          r_total  <= TW'(tamano) * TW'(tamano);
          r_k      <= '0;
          r_emit   <= '0;
          r_fila   <= '0;
          r_col    <= '0;
          r_estado <= (tamano != '0) ? LEYENDO : FIN;
        end
        LEYENDO: if (w_pop && (r_emit == r_total - TW'(1))) r_estado <= FIN;
        FIN:     r_estado <= REPOSO;
        default: r_estado <= REPOSO;
      endcase

      r_pend <= w_issue;
      if (w_issue) begin
        r_k     <= r_k + TW'(1);
        r_dir   <= w_dir;
        r_pfila <= r_fila;
        r_pcol  <= r_col;
        if (r_col == r_n - BITS_MASCARA'(1)) begin
          r_col  <= '0;
          r_fila <= r_fila + BITS_MASCARA'(1);
        end else begin
          r_col  <= r_col + BITS_MASCARA'(1);
        end
      end

      if (w_pop) r_emit <= r_emit + TW'(1);

      // Entry 0 is always the head; a pop shifts entry 1 down.
      case ({r_pend, w_pop})
        2'b10: begin
          r_fifo[r_cnt[0]] <= w_new;
          r_cnt            <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_fifo[0] <= r_fifo[1];
          r_cnt     <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_fifo[0] <= r_fifo[1];
            r_fifo[1] <= w_new;
          end else begin
            r_fifo[0] <= w_new;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
